// File: rtl/uart_frame_ctrl.sv
// Command-frame controller behind uart_rx: parses HEADER/CMD/ADDR/DATA/CHK frames,
// issues register bus strobes and returns read data through a uart_tx handshake.
module uart_frame_ctrl #(
    parameter logic [7:0]  HEADER      = 8'h55,
    parameter logic [7:0]  CMD_WR      = 8'h01,
    parameter logic [7:0]  CMD_RD      = 8'h02,
    parameter int unsigned TIMEOUT_END = 52079
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic [7:0] rx_data,
    input  logic       po_flag,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       frame_err,
    output logic [1:0] err_code
);
    localparam int CNT_W = $clog2(TIMEOUT_END + 1);

    typedef enum logic [3:0] {
        IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC_WR, EXEC_RD, RD_CAP, TX_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       addr_d, wdata_d, tx_data_d;
    logic             wr_en_d, rd_en_d, tx_start_d, err_d;
    logic [1:0]       code_d;
    logic             in_frame, timeout;

    function automatic logic [7:0] frame_chk(input logic [7:0] c, input logic [7:0] a,
                                             input logic [7:0] d);
        return c ^ a ^ d;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        cmd_d      = cmd_q;
        addr_d     = reg_addr;
        wdata_d    = reg_wdata;
        tx_data_d  = tx_data;
        code_d     = err_code;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        tx_start_d = 1'b0;
        err_d      = 1'b0;
        in_frame   = state_q inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK};
        timeout    = (cnt_q == CNT_W'(TIMEOUT_END - 1));

        // Inter-byte gap counter; any received byte restarts it.
        if (in_frame && !po_flag) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (po_flag && rx_data == HEADER) begin
                    state_d = GET_CMD;
                end
            end
            GET_CMD: begin
                if (po_flag) begin
                    cmd_d   = rx_data;
                    state_d = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (po_flag) begin
                    addr_d  = rx_data;
                    state_d = GET_DATA;
                end
            end
            GET_DATA: begin
                if (po_flag) begin
                    wdata_d = rx_data;
                    state_d = GET_CHK;
                end
            end
            GET_CHK: begin
                if (po_flag) begin
                    state_d = IDLE;
                    if (rx_data != frame_chk(cmd_q, reg_addr, reg_wdata)) begin
                        err_d  = 1'b1;
                        code_d = 2'd1;
                    end else if (cmd_q == CMD_WR) begin
                        wr_en_d = 1'b1;
                        state_d = EXEC_WR;
                    end else if (cmd_q == CMD_RD) begin
                        rd_en_d = 1'b1;
                        state_d = EXEC_RD;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd2;
                    end
                end
            end
            EXEC_WR: state_d = IDLE;
            EXEC_RD: state_d = RD_CAP;
            RD_CAP: begin
                tx_data_d  = reg_rdata;
                tx_start_d = !tx_busy;
                state_d    = TX_WAIT;
            end
            // Stay until the start pulse has been presented for one cycle.
            TX_WAIT: begin
                if (tx_start) begin
                    state_d = IDLE;
                end else begin
                    tx_start_d = !tx_busy;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_frame && !po_flag && timeout) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
            code_d  = 2'd3;
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            tx_data   <= '0;
            err_code  <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            tx_start  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            reg_addr  <= addr_d;
            reg_wdata <= wdata_d;
            tx_data   <= tx_data_d;
            err_code  <= code_d;
            reg_wr_en <= wr_en_d;
            reg_rd_en <= rd_en_d;
            tx_start  <= tx_start_d;
            frame_err <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: byte-level frame model compared every cycle,
// plus directed frames with literal expectations.
module tb_uart_frame_ctrl;
    localparam int TIMEOUT_END = 52079;

    logic       sclk = 1'b0;
    logic       s_rst;
    logic [7:0] rx_data;
    logic       po_flag;
    logic       reg_wr_en, reg_rd_en;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       frame_err;
    logic [1:0] err_code;

    uart_frame_ctrl #(.TIMEOUT_END(TIMEOUT_END)) dut (
        .sclk      (sclk),
        .s_rst     (s_rst),
        .rx_data   (rx_data),
        .po_flag   (po_flag),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 sclk = ~sclk;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt = 0, rd_cnt = 0, txs_cnt = 0, err_cnt = 0;

    // Expected outputs, produced by the frame model.
    logic       m_live = 1'b0;
    logic       e_wr = 1'b0, e_rd = 1'b0, e_txs = 1'b0, e_err = 1'b0;
    logic [7:0] e_addr = 8'h00, e_wdata = 8'h00, e_tx = 8'h00;
    logic [1:0] e_code = 2'd0;
    int         m_n = 0, m_idle = 0, m_since = 0;
    logic       m_lock = 1'b0, m_rd = 1'b0, m_fired = 1'b0;
    logic [7:0] m_cmd = 8'h00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, required %0h", name, $time, got, exp);
        end
    endtask

    // Model: count bytes of a frame, then walk the post-frame reply timeline.
    initial begin
        forever begin
            @(posedge sclk);
            m_live = 1'b1;
            e_wr = 1'b0; e_rd = 1'b0; e_txs = 1'b0; e_err = 1'b0;
            if (s_rst) begin
                m_n = 0; m_idle = 0; m_lock = 1'b0;
                e_addr = 8'h00; e_wdata = 8'h00; e_tx = 8'h00; e_code = 2'd0;
            end else if (m_lock) begin
                m_since++;
                if (m_rd && m_since == 2) e_tx = reg_rdata;
                if (!m_rd || m_fired) begin
                    m_lock = 1'b0;
                end else if (m_since >= 2 && !tx_busy) begin
                    e_txs   = 1'b1;
                    m_fired = 1'b1;
                end
            end else if (po_flag) begin
                m_idle = 0;
                case (m_n)
                    0: if (rx_data == 8'h55) m_n = 1;
                    1: begin m_cmd = rx_data; m_n = 2; end
                    2: begin e_addr = rx_data; m_n = 3; end
                    3: begin e_wdata = rx_data; m_n = 4; end
                    default: begin
                        m_n = 0;
                        if (rx_data != (m_cmd ^ e_addr ^ e_wdata)) begin
                            e_err = 1'b1; e_code = 2'd1;
                        end else if (m_cmd == 8'h01) begin
                            e_wr = 1'b1; m_lock = 1'b1; m_rd = 1'b0; m_since = 0;
                        end else if (m_cmd == 8'h02) begin
                            e_rd = 1'b1; m_lock = 1'b1; m_rd = 1'b1; m_fired = 1'b0; m_since = 0;
                        end else begin
                            e_err = 1'b1; e_code = 2'd2;
                        end
                    end
                endcase
            end else if (m_n != 0) begin
                m_idle++;
                if (m_idle == TIMEOUT_END) begin
                    e_err = 1'b1; e_code = 2'd3; m_n = 0; m_idle = 0;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge sclk);
            if (m_live) begin
                chk("reg_wr_en", 32'(reg_wr_en), 32'(e_wr));
                chk("reg_rd_en", 32'(reg_rd_en), 32'(e_rd));
                chk("reg_addr",  32'(reg_addr),  32'(e_addr));
                chk("reg_wdata", 32'(reg_wdata), 32'(e_wdata));
                chk("tx_data",   32'(tx_data),   32'(e_tx));
                chk("tx_start",  32'(tx_start),  32'(e_txs));
                chk("frame_err", 32'(frame_err), 32'(e_err));
                chk("err_code",  32'(err_code),  32'(e_code));
                if (reg_wr_en === 1'b1) wr_cnt++;
                if (reg_rd_en === 1'b1) rd_cnt++;
                if (tx_start === 1'b1)  txs_cnt++;
                if (frame_err === 1'b1) err_cnt++;
            end
        end
    end

    initial begin
        #990000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge sclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        tick();
        rx_data = b;
        po_flag = 1'b1;
        tick();
        po_flag = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        int   w0, r0, t0, f0, k;
        logic ok;
        s_rst = 1'b1; po_flag = 1'b0; rx_data = 8'h00; reg_rdata = 8'h00; tx_busy = 1'b0;
        repeat (3) tick();
        chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
        chk("rst_addr",  32'(reg_addr),  32'd0);
        chk("rst_txdata", 32'(tx_data),  32'd0);
        chk("rst_code",  32'(err_code),  32'd0);
        s_rst = 1'b0;
        tick();

        // Write frame with UART-rate byte spacing.
        w0 = wr_cnt; r0 = rd_cnt; f0 = err_cnt;
        send_byte(8'h55, 5208); send_byte(8'h01, 5208); send_byte(8'h10, 5208);
        send_byte(8'hA5, 5208); send_byte(8'hB4, 0);
        chk("wr_strobe", 32'(reg_wr_en), 32'd1);
        chk("wr_addr",   32'(reg_addr),  32'h10);
        chk("wr_wdata",  32'(reg_wdata), 32'hA5);
        tick();
        chk("wr_strobe_end", 32'(reg_wr_en), 32'd0);
        repeat (3) tick();
        chk("wr_count",  32'(wr_cnt - w0), 32'd1);
        chk("wr_no_rd",  32'(rd_cnt - r0), 32'd0);
        chk("wr_no_err", 32'(err_cnt - f0), 32'd0);

        // Read frame, transmitter idle.
        reg_rdata = 8'h3C; t0 = txs_cnt;
        send_byte(8'h55, 3); send_byte(8'h02, 3); send_byte(8'h20, 3);
        send_byte(8'h00, 3); send_byte(8'h22, 0);
        chk("rd_strobe", 32'(reg_rd_en), 32'd1);
        chk("rd_addr",   32'(reg_addr),  32'h20);
        tick();
        chk("rd_tx_early", 32'(tx_start), 32'd0);
        tick();
        chk("rd_tx_start", 32'(tx_start), 32'd1);
        chk("rd_tx_data",  32'(tx_data),  32'h3C);
        tick();
        chk("rd_tx_end", 32'(tx_start), 32'd0);
        chk("rd_tx_count", 32'(txs_cnt - t0), 32'd1);

        // Read frame held off by a busy transmitter.
        tx_busy = 1'b1;
        send_byte(8'h55, 3); send_byte(8'h02, 3); send_byte(8'h20, 3);
        send_byte(8'h00, 3); send_byte(8'h22, 0);
        tick(); tick();
        chk("busy_no_start", 32'(tx_start), 32'd0);
        reg_rdata = 8'h99;
        ok = 1'b1;
        repeat (100) begin
            tick();
            if (tx_start !== 1'b0 || tx_data !== 8'h3C) ok = 1'b0;
        end
        chk("busy_hold", 32'(ok), 32'd1);
        tx_busy = 1'b0;
        tick();
        chk("busy_release_start", 32'(tx_start), 32'd1);
        chk("busy_release_data",  32'(tx_data),  32'h3C);
        tick();
        chk("busy_release_end", 32'(tx_start), 32'd0);

        // Bad checksum, then unknown command.
        w0 = wr_cnt; r0 = rd_cnt;
        send_byte(8'h55, 3); send_byte(8'h01, 3); send_byte(8'h10, 3);
        send_byte(8'hA5, 3); send_byte(8'h00, 0);
        chk("chk_err",  32'(frame_err), 32'd1);
        chk("chk_code", 32'(err_code),  32'd1);
        send_byte(8'h55, 3); send_byte(8'h07, 3); send_byte(8'h00, 3);
        send_byte(8'h00, 3); send_byte(8'h07, 0);
        chk("cmd_code", 32'(err_code), 32'd2);
        repeat (3) tick();
        chk("err_no_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);

        // Garbage, partial frame, silence until timeout; then a good write.
        send_byte(8'h12, 3); send_byte(8'h34, 3); send_byte(8'h55, 3); send_byte(8'h01, 0);
        k = 0;
        while (frame_err !== 1'b1 && k < TIMEOUT_END + 20) begin
            tick();
            k++;
        end
        chk("timeout_cycles", 32'(k), 32'd52079);
        chk("timeout_code",   32'(err_code), 32'd3);
        w0 = wr_cnt;
        send_byte(8'h55, 3); send_byte(8'h01, 3); send_byte(8'h33, 3);
        send_byte(8'h44, 3); send_byte(8'h76, 0);
        chk("post_to_wr",   32'(reg_wr_en), 32'd1);
        chk("post_to_addr", 32'(reg_addr),  32'h33);
        repeat (3) tick();
        chk("post_to_count", 32'(wr_cnt - w0), 32'd1);

        // Reset in the middle of a write frame.
        w0 = wr_cnt;
        send_byte(8'h55, 3); send_byte(8'h01, 3); send_byte(8'h10, 3);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        chk("mid_rst_outputs", {8'h00, reg_addr, reg_wdata, tx_data},  32'd0);
        chk("mid_rst_flags", 32'({reg_wr_en, reg_rd_en, tx_start, frame_err, err_code}), 32'd0);
        send_byte(8'hA5, 3); send_byte(8'hB4, 5);
        chk("mid_rst_no_wr", 32'(wr_cnt - w0), 32'd0);
        chk("mid_rst_addr",  32'(reg_addr), 32'd0);

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
